// File: rtl/vram_ctrl_pkg.sv
// vram_ctrl_pkg: shared sizes, FSM states, grant encoding and address helpers for the VRAM write controller
package vram_ctrl_pkg;
  localparam int VRAM_DEPTH = 4800;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 8;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(VRAM_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(VRAM_DEPTH - 1);
  typedef enum logic {ST_IDLE, ST_FILL} st_e;
  typedef enum logic [1:0] {GNT_NONE, GNT_CPU, GNT_FILL} gnt_sel_e;
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + 1'b1;
  endfunction
  function automatic logic [ADDR_W-1:0] clamp_len(input logic [ADDR_W-1:0] l);
    return (l > DEPTH_A) ? DEPTH_A : l;
  endfunction
endpackage

// File: rtl/vram_write_ctrl_if.sv
// vram_write_ctrl_if: CPU store, fill engine and VRAM write-port signals of the VRAM write controller
interface vram_write_ctrl_if;
  import vram_ctrl_pkg::*;
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic              fill_start;
  logic [ADDR_W-1:0] fill_base;
  logic [ADDR_W-1:0] fill_len;
  logic [DATA_W-1:0] fill_char;
  logic              fill_busy;
  logic              fill_done;
  logic              wo_wmode;
  logic [ADDR_W-1:0] wo_addr;
  logic [DATA_W-1:0] wo_wdata;
  modport master (
    output cpu_req, cpu_addr, cpu_wdata, fill_start, fill_base, fill_len, fill_char,
    input  cpu_ack, fill_busy, fill_done, wo_wmode, wo_addr, wo_wdata
  );
  modport slave (
    input  cpu_req, cpu_addr, cpu_wdata, fill_start, fill_base, fill_len, fill_char,
    output cpu_ack, fill_busy, fill_done, wo_wmode, wo_addr, wo_wdata
  );
endinterface

// File: rtl/vram_rr_arb.sv
// vram_rr_arb: two-way arbiter, req[0]=CPU req[1]=fill; round-robin when rr_en, CPU-first otherwise
module vram_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic       rr_en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic ptr;
  logic fav_fill;
  // grant the favoured side on contention, otherwise whoever asks
  always_comb begin
    fav_fill = rr_en & ptr;
    gnt[0] = req[0] & ~(req[1] & fav_fill);
    gnt[1] = req[1] & ~(req[0] & ~fav_fill);
  end
  // pointer moves to the other requester after each grant; stays on CPU in fixed mode
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= 1'b0;
    else if (|gnt) ptr <= rr_en & gnt[0];
endmodule

// File: rtl/vram_write_ctrl.sv
// vram_write_ctrl: shares the VRAM write port between CPU byte stores and a fill engine (VRAM_WRITE_CTRL_RR_EN selects round-robin)
module vram_write_ctrl
  import vram_ctrl_pkg::*;
(
  input logic clk,
  input logic rst,
  vram_write_ctrl_if.slave bus
);
`ifdef VRAM_WRITE_CTRL_RR_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif
  st_e               st;
  gnt_sel_e          sel;
  logic [1:0]        req;
  logic [1:0]        gnt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] rem;
  logic [DATA_W-1:0] chr;
  logic              busy;
  logic              done;
  logic              ack;
  logic              wmode;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  // CPU sits out the cycle its previous write is on the port, so one request never writes twice
  always_comb begin
    req = {st == ST_FILL, bus.cpu_req & ~ack};
    sel = gnt[0] ? GNT_CPU : gnt[1] ? GNT_FILL : GNT_NONE;
  end
  vram_rr_arb u_arb (
    .clk   (clk),
    .rst   (rst),
    .rr_en (RR_EN),
    .req   (req),
    .gnt   (gnt)
  );
  // fill FSM and registered write port: a grant in one cycle is the write of the next
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st    <= ST_IDLE;
      ptr   <= '0;
      rem   <= '0;
      chr   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      ack   <= 1'b0;
      wmode <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else begin
      ack   <= sel == GNT_CPU;
      done  <= 1'b0;
      wmode <= 1'b0;
      if (done) busy <= 1'b0;
      case (st)
        ST_IDLE:
          if (bus.fill_start && !busy) begin
            if (bus.fill_len == '0) done <= 1'b1;
            else begin
              st   <= ST_FILL;
              busy <= 1'b1;
              ptr  <= bus.fill_base;
              rem  <= clamp_len(bus.fill_len);
              chr  <= bus.fill_char;
            end
          end
        ST_FILL:
          if (sel == GNT_FILL) begin
            ptr <= next_addr(ptr);
            rem <= rem - 1'b1;
            if (rem == ADDR_W'(1)) begin
              st   <= ST_IDLE;
              done <= 1'b1;
            end
          end
        default: st <= ST_IDLE;
      endcase
      if (sel == GNT_CPU && bus.cpu_addr < DEPTH_A) begin
        wmode <= 1'b1;
        waddr <= bus.cpu_addr;
        wdata <= bus.cpu_wdata;
      end
      if (sel == GNT_FILL) begin
        wmode <= 1'b1;
        waddr <= ptr;
        wdata <= chr;
      end
    end
  assign bus.cpu_ack   = ack;
  assign bus.fill_busy = busy;
  assign bus.fill_done = done;
  assign bus.wo_wmode  = wmode;
  assign bus.wo_addr   = waddr;
  assign bus.wo_wdata  = wdata;
endmodule

// File: tb/tb_vram_write_ctrl.sv
// tb_vram_write_ctrl: directed self-checking bench for vram_write_ctrl
module tb_vram_write_ctrl;
  import vram_ctrl_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [20:0] wq[$];
  vram_write_ctrl_if bus();
  vram_write_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.wo_wmode) wq.push_back({bus.wo_addr, bus.wo_wdata});
    if (bus.fill_done) done_cnt++;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic check_zero_outs(input string tag);
    check({tag, "_wmode"}, 32'(bus.wo_wmode), 0);
    check({tag, "_addr"}, 32'(bus.wo_addr), 0);
    check({tag, "_wdata"}, 32'(bus.wo_wdata), 0);
    check({tag, "_ack"}, 32'(bus.cpu_ack), 0);
    check({tag, "_busy"}, 32'(bus.fill_busy), 0);
    check({tag, "_done"}, 32'(bus.fill_done), 0);
  endtask
  task automatic wait_done(input int budget, output bit seen);
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (bus.fill_done) seen = 1;
    end
  endtask
  task automatic pulse_fill(input int base, input int len, input int ch);
    bus.fill_base  = ADDR_W'(base);
    bus.fill_len   = ADDR_W'(len);
    bus.fill_char  = DATA_W'(ch);
    bus.fill_start = 1'b1;
    tick();
    bus.fill_start = 1'b0;
  endtask
  logic [20:0] exp_c[12];
  bit seen;
  int bad;
  int n;
  int d0;
  initial begin
    exp_c = '{{13'd200, 8'h30}, {13'd100, 8'h2A}, {13'd201, 8'h31}, {13'd101, 8'h2A},
              {13'd202, 8'h32}, {13'd102, 8'h2A}, {13'd203, 8'h33}, {13'd103, 8'h2A},
              {13'd104, 8'h2A}, {13'd105, 8'h2A}, {13'd106, 8'h2A}, {13'd107, 8'h2A}};
    bus.cpu_req = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.fill_start = 1'b0; bus.fill_base = '0; bus.fill_len = '0; bus.fill_char = '0;
    repeat (3) tick();
    check_zero_outs("reset");
    rst = 1'b0;
    repeat (4) tick();
    check("idle_wmode", 32'(bus.wo_wmode), 0);
    check("idle_writes", 32'(wq.size()), 0);
    // CPU single write
    bus.cpu_req = 1'b1; bus.cpu_addr = 13'h0050; bus.cpu_wdata = 8'h41;
    tick();
    check("cpu_wmode", 32'(bus.wo_wmode), 1);
    check("cpu_addr", 32'(bus.wo_addr), 32'h50);
    check("cpu_wdata", 32'(bus.wo_wdata), 32'h41);
    check("cpu_ack", 32'(bus.cpu_ack), 1);
    bus.cpu_req = 1'b0;
    tick();
    check("cpu_ack_drop", 32'(bus.cpu_ack), 0);
    check("cpu_wmode_drop", 32'(bus.wo_wmode), 0);
    tick();
    check("cpu_one_write", 32'(wq.size()), 1);
    // full clear
    wq.delete();
    d0 = done_cnt;
    pulse_fill(0, 4800, 8'h20);
    check("clr_busy", 32'(bus.fill_busy), 1);
    wait_done(5000, seen);
    check("clr_done_seen", 32'(seen), 1);
    check("clr_done_addr", 32'(bus.wo_addr), 4799);
    check("clr_done_wmode", 32'(bus.wo_wmode), 1);
    check("clr_done_busy", 32'(bus.fill_busy), 1);
    tick();
    check("clr_busy_fall", 32'(bus.fill_busy), 0);
    check("clr_done_fall", 32'(bus.fill_done), 0);
    check("clr_count", 32'(wq.size()), 4800);
    bad = 0;
    foreach (wq[i]) if (wq[i] !== {13'(i), 8'h20}) bad++;
    check("clr_bad_writes", 32'(bad), 0);
    check("clr_done_cnt", 32'(done_cnt - d0), 1);
    // wrap
    wq.delete();
    pulse_fill(4798, 4, 8'h55);
    wait_done(20, seen);
    check("wrap_done_seen", 32'(seen), 1);
    tick();
    check("wrap_count", 32'(wq.size()), 4);
    if (wq.size() == 4) begin
      check("wrap_w0", 32'(wq[0]), 32'({13'd4798, 8'h55}));
      check("wrap_w1", 32'(wq[1]), 32'({13'd4799, 8'h55}));
      check("wrap_w2", 32'(wq[2]), 32'({13'd0, 8'h55}));
      check("wrap_w3", 32'(wq[3]), 32'({13'd1, 8'h55}));
    end
    // zero length
    wq.delete();
    pulse_fill(10, 0, 8'h66);
    check("zero_done", 32'(bus.fill_done), 1);
    check("zero_busy", 32'(bus.fill_busy), 0);
    check("zero_wmode", 32'(bus.wo_wmode), 0);
    tick();
    check("zero_done_fall", 32'(bus.fill_done), 0);
    repeat (3) tick();
    check("zero_no_writes", 32'(wq.size()), 0);
    // out-of-range CPU write; port keeps the last write's address/data
    bus.cpu_req = 1'b1; bus.cpu_addr = 13'd4800; bus.cpu_wdata = 8'h99;
    tick();
    check("oor_ack", 32'(bus.cpu_ack), 1);
    check("oor_wmode", 32'(bus.wo_wmode), 0);
    check("oor_addr_hold", 32'(bus.wo_addr), 1);
    check("oor_wdata_hold", 32'(bus.wo_wdata), 32'h55);
    bus.cpu_req = 1'b0;
    tick();
    check("oor_ack_drop", 32'(bus.cpu_ack), 0);
    tick();
    check("oor_no_writes", 32'(wq.size()), 0);
    // contention with a streaming CPU, plus an ignored fill_start mid-fill
    wq.delete();
    d0 = done_cnt;
    bus.fill_base = 13'd100; bus.fill_len = 13'd8; bus.fill_char = 8'h2A; bus.fill_start = 1'b1;
    bus.cpu_req = 1'b1; bus.cpu_addr = 13'd200; bus.cpu_wdata = 8'h30;
    n = 0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      bus.fill_start = (i == 2);
      if (i == 2) begin bus.fill_base = 13'd3000; bus.fill_len = 13'd5; bus.fill_char = 8'h77; end
      if (bus.cpu_ack) begin
        n++;
        if (n == 4) bus.cpu_req = 1'b0;
        else begin bus.cpu_addr = 13'(200 + n); bus.cpu_wdata = 8'(8'h30 + n); end
      end
      if (bus.fill_done) seen = 1;
    end
    check("ct_done_seen", 32'(seen), 1);
    repeat (3) tick();
    check("ct_busy_fall", 32'(bus.fill_busy), 0);
    check("ct_count", 32'(wq.size()), 12);
    check("ct_done_cnt", 32'(done_cnt - d0), 1);
    bad = 0;
    if (wq.size() == 12) foreach (exp_c[i]) if (wq[i] !== exp_c[i]) bad++;
    check("ct_bad_writes", 32'(bad), 0);
    // reset mid-fill
    d0 = done_cnt;
    pulse_fill(0, 100, 8'h11);
    repeat (5) tick();
    check("rst_pre_busy", 32'(bus.fill_busy), 1);
    #2 rst = 1'b1;
    #1;
    check_zero_outs("rst_mid");
    #1 rst = 1'b0;
    tick();
    wq.delete();
    repeat (10) tick();
    check("rst_no_writes", 32'(wq.size()), 0);
    check("rst_no_done", 32'(done_cnt - d0), 0);
    check("rst_busy_low", 32'(bus.fill_busy), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
